// File: rtl/uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_ctrl
// Purpose : Drains the TX FIFO one word at a time and hands each word to the
//           UART serializer. Optional inter-frame gap: UART_TXCTRL_GAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo_ctrl #(
  parameter int DATA_SIZE    = 8,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 fifo_empty,
  input  logic                 fifo_valid,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [DATA_SIZE-1:0] tx_data,
  output logic                 active,
  output logic [15:0]          sent_count,
  output logic                 error
);

  localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'(BUSY_TIMEOUT);

`ifdef UART_TXCTRL_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_START, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;
`endif

  state_t               state_q, state_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [15:0]          sent_count_q, sent_count_d;
  logic                 error_q, error_d;
  logic [TO_W-1:0]      to_cnt_inc;

  assign to_cnt_inc = to_cnt_q + TO_W'(1);

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    to_cnt_d     = to_cnt_q;
    sent_count_d = sent_count_q;
    error_d      = error_q;
`ifdef UART_TXCTRL_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run && !fifo_empty && !tx_busy) state_d = S_READ;
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (fifo_valid) begin
          tx_data_d = fifo_data;
          state_d   = S_START;
        end else begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_inc;
          // Transmitter never acknowledged the start: give up on this frame.
          if (to_cnt_inc == C_TO_LIMIT) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          sent_count_d = sent_count_q + 16'd1;
`ifdef UART_TXCTRL_GAP_EN
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_TXCTRL_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == C_GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, decoded from the state being entered.
    fifo_read_d = (state_d == S_READ);
    tx_start_d  = (state_d == S_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fifo_read_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      to_cnt_q     <= '0;
      sent_count_q <= '0;
      error_q      <= 1'b0;
`ifdef UART_TXCTRL_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fifo_read_q  <= fifo_read_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      to_cnt_q     <= to_cnt_d;
      sent_count_q <= sent_count_d;
      error_q      <= error_d;
`ifdef UART_TXCTRL_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign fifo_read  = fifo_read_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign active     = (state_q != S_IDLE);
  assign sent_count = sent_count_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo_ctrl
// Purpose : Directed self-checking bench with FIFO and transmitter models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_ctrl;

`ifdef UART_TXCTRL_GAP_EN
  localparam int EXP_REFETCH = 18;
`else
  localparam int EXP_REFETCH = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        fifo_empty;
  logic        fifo_valid = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_read;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        active;
  logic [15:0] sent_count;
  logic        error;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_ctrl #(
    .DATA_SIZE(8), .GAP_CYCLES(16), .BUSY_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .fifo_empty(fifo_empty), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .active(active), .sent_count(sent_count), .error(error)
  );

  always #5 clk = ~clk;

  // FIFO model: data one cycle after an accepted read
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int read_cnt = 0;
  bit force_invalid = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    fifo_valid <= 1'b0;
    if (fifo_read) begin
      read_cnt <= read_cnt + 1;
      if (!force_invalid && wr_ptr != rd_ptr) begin
        fifo_valid <= 1'b1;
        fifo_data  <= mem[rd_ptr % 16];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  // Transmitter model: busy for busy_len clocks after each start
  int busy_len = 20;
  int busy_rem = 0;
  bit tx_dead = 1'b0;
  int start_cnt = 0;
  bit overlap = 1'b0;
  logic [7:0] start_log [0:31];

  always @(posedge clk) begin
    if (fifo_read && tx_start) overlap <= 1'b1;
    if (tx_start) begin
      start_log[start_cnt % 32] <= tx_data;
      start_cnt <= start_cnt + 1;
      if (!tx_dead) begin
        tx_busy  <= 1'b1;
        busy_rem <= busy_len - 1;
      end
    end else if (tx_busy) begin
      if (busy_rem > 0) busy_rem <= busy_rem - 1;
      else tx_busy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0;
    tick(); tick();
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read got %b want 0", fifo_read); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", active); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL rst_sent got %0d want 0", sent_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error); end
    reset = 1'b0;
  endtask

  task automatic test_idle_empty();
    int rc0;
    bit seen;
    rc0 = read_cnt; seen = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fifo_read || tx_start || active) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL empty_activity got %b want 0", seen); end
    checks++; if (read_cnt !== rc0) begin errors++; $display("FAIL empty_reads got %0d want %0d", read_cnt, rc0); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL empty_sent got %0d want 0", sent_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL empty_error got %b want 0", error); end
  endtask

  task automatic test_back_to_back();
    int rc0, sc0, d;
    rc0 = read_cnt; sc0 = start_cnt;
    push(8'hA5); push(8'h3C);
    tick();
    checks++; if ({active, fifo_read, tx_start} !== 3'b110) begin errors++; $display("FAIL b2b_read_cycle got %b want 110", {active, fifo_read, tx_start}); end
    tick();
    checks++; if ({fifo_read, tx_start} !== 2'b00) begin errors++; $display("FAIL b2b_capture_cycle got %b want 00", {fifo_read, tx_start}); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL b2b_start_latency got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL b2b_data0 got %h want a5", tx_data); end
    for (int i = 0; i < 50 && !tx_busy; i++) tick();
    for (int i = 0; i < 50 && tx_busy; i++) tick();
    d = 0;
    for (int i = 0; i < 60 && !fifo_read; i++) begin tick(); d++; end
    checks++; if (d !== EXP_REFETCH) begin errors++; $display("FAIL b2b_refetch_clocks got %0d want %0d", d, EXP_REFETCH); end
    for (int i = 0; i < 200 && sent_count != 16'd2; i++) tick();
    checks++; if (sent_count !== 16'd2) begin errors++; $display("FAIL b2b_sent got %0d want 2", sent_count); end
    checks++; if (read_cnt - rc0 !== 2) begin errors++; $display("FAIL b2b_reads got %0d want 2", read_cnt - rc0); end
    checks++; if (start_log[sc0 % 32] !== 8'hA5) begin errors++; $display("FAIL b2b_log0 got %h want a5", start_log[sc0 % 32]); end
    checks++; if (start_log[(sc0 + 1) % 32] !== 8'h3C) begin errors++; $display("FAIL b2b_log1 got %h want 3c", start_log[(sc0 + 1) % 32]); end
    tick();
    checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL b2b_data_hold got %h want 3c", tx_data); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", active); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL b2b_error got %b want 0", error); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL b2b_overlap got %b want 0", overlap); end
  endtask

  task automatic test_bad_read();
    int sc0;
    logic [15:0] base;
    sc0 = start_cnt; base = sent_count;
    force_invalid = 1'b1;
    push(8'h5A);
    tick(); tick(); tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_error got %b want 1", error); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL bad_idle got %b want 0", active); end
    checks++; if (start_cnt !== sc0) begin errors++; $display("FAIL bad_no_start got %0d want %0d", start_cnt, sc0); end
    force_invalid = 1'b0;
    for (int i = 0; i < 200 && sent_count != base + 16'd1; i++) tick();
    checks++; if (sent_count !== base + 16'd1) begin errors++; $display("FAIL bad_recover_sent got %0d want %0d", sent_count, base + 16'd1); end
    checks++; if (start_log[sc0 % 32] !== 8'h5A) begin errors++; $display("FAIL bad_recover_data got %h want 5a", start_log[sc0 % 32]); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", error); end
  endtask

  task automatic test_timeout();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    tx_dead = 1'b1;
    push(8'h77);
    for (int i = 0; i < 20 && !tx_start; i++) tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", tx_start); end
    n = 0;
    while (!error && n < 400) begin
      tick();
      if (!error) n++;
    end
    checks++; if (n !== 255) begin errors++; $display("FAIL to_wait_clocks got %0d want 255", n); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error got %b want 1", error); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL to_sent got %0d want 0", sent_count); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL to_idle got %b want 0", active); end
    tx_dead = 1'b0;
  endtask

  task automatic test_run_drop();
    int rc0, sc0;
    logic [15:0] base;
    rc0 = read_cnt; sc0 = start_cnt; base = sent_count;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (5) tick();
    run = 1'b0;
    for (int i = 0; i < 200 && sent_count != base + 16'd1; i++) tick();
    repeat (40) tick();
    checks++; if (sent_count !== base + 16'd1) begin errors++; $display("FAIL drop_sent got %0d want %0d", sent_count, base + 16'd1); end
    checks++; if (read_cnt - rc0 !== 1) begin errors++; $display("FAIL drop_reads got %0d want 1", read_cnt - rc0); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL drop_idle got %b want 0", active); end
    run = 1'b1;
    for (int i = 0; i < 300 && sent_count != base + 16'd3; i++) tick();
    checks++; if (sent_count !== base + 16'd3) begin errors++; $display("FAIL resume_sent got %0d want %0d", sent_count, base + 16'd3); end
    checks++; if (start_log[(sc0 + 1) % 32] !== 8'h22) begin errors++; $display("FAIL resume_data1 got %h want 22", start_log[(sc0 + 1) % 32]); end
    checks++; if (start_log[(sc0 + 2) % 32] !== 8'h33) begin errors++; $display("FAIL resume_data2 got %h want 33", start_log[(sc0 + 2) % 32]); end
  endtask

  task automatic test_reset_mid_frame();
    push(8'h44);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    checks++; if ({fifo_read, tx_start, active, error} !== 4'b0000) begin errors++; $display("FAIL midrst_flags got %b want 0000", {fifo_read, tx_start, active, error}); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data got %h want 00", tx_data); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL midrst_sent got %0d want 0", sent_count); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_back_to_back();
    test_bad_read();
    test_timeout();
    test_run_drop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
